led_status_multi: RTL and testbench

LED_STATUS_MULTI -- requirements
Module: led_status_multi

---
 rtl/led_status_pkg.sv | 27 ++
 rtl/led_status_ch.sv | 150 +++++++++++++++
 rtl/led_status_multi.sv | 57 +++++
 tb/tb_led_status_multi.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_status_pkg.sv
// Purpose : shared types, constants and helpers for the multi-channel LED status block.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: ch_state_e channel FSM states, CODE_GAP dark ticks after an error-code burst,
//           clog2() width helper used to size the prescaler and per-channel counters.
package led_status_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2
   } ch_state_e;

   // Dark ticks appended after each burst of error-code pulses.
   localparam int CODE_GAP = 8;

   // ceil(log2(v)), never less than 1, so the result can always size a register.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/led_status_ch.sv
// Purpose : one result channel: IDLE/PASS/FAIL FSM, blink phase counter, optional code sequencer.
// Latency : outputs registered; a done pulse is visible on led_o/busy_o one edge later.
// Backpressure: none; done_i is accepted in every state and always re-latches the channel.
// Ports   : clk, rst_n (async, active-low); tick_i shared base tick; done_i/pass_i/code_i result
//           strobe with pass flag and error code; clr_i global clear (done_i wins);
//           led_o LED drive; busy_o high while a result is latched.
// Config  : LED_STATUS_ERRCODE_EN adds code storage and the pulse-code display in FAIL.
module led_status_ch
   import led_status_pkg::*;
#(
   parameter int BLINK_TICKS = 4,
   parameter int CODE_W      = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_i,
   input  logic              done_i,
   input  logic              pass_i,
   input  logic [CODE_W-1:0] code_i,
   input  logic              clr_i,
   output logic              led_o,
   output logic              busy_o
);

   localparam int               PH_W    = clog2(BLINK_TICKS);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(BLINK_TICKS - 1);

   ch_state_e         state_q, state_d;
   logic              led_q, led_d;
   logic              busy_q, busy_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              use_code;

`ifdef LED_STATUS_ERRCODE_EN
   // Slot index within one code frame: 2*code pulse/dark slots, then CODE_GAP dark slots.
   localparam int POS_W = clog2(2 * ((1 << CODE_W) - 1) + CODE_GAP);

   logic [CODE_W-1:0] code_q, code_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [POS_W-1:0]  pulse_end;
   logic [POS_W-1:0]  seq_last;

   assign use_code  = (code_q != '0);
   assign pulse_end = POS_W'({code_q, 1'b0});
   assign seq_last  = pulse_end + POS_W'(CODE_GAP - 1);
`else
   logic unused_code;
   assign unused_code = ^code_i;
   assign use_code    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      busy_d  = busy_q;
      phase_d = phase_q;
`ifdef LED_STATUS_ERRCODE_EN
      code_d  = code_q;
      pos_d   = pos_q;
`endif
      if (done_i) begin
         // New result restarts the channel from entry, whatever state it was in.
         busy_d  = 1'b1;
         phase_d = '0;
         if (pass_i) begin
            state_d = PASS;
            led_d   = 1'b1;
         end else begin
            state_d = FAIL;
            led_d   = 1'b0;
         end
`ifdef LED_STATUS_ERRCODE_EN
         code_d = pass_i ? '0 : code_i;
         pos_d  = '0;
`endif
      end else if (clr_i) begin
         state_d = IDLE;
         led_d   = 1'b0;
         busy_d  = 1'b0;
         phase_d = '0;
`ifdef LED_STATUS_ERRCODE_EN
         code_d  = '0;
         pos_d   = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               led_d  = 1'b0;
               busy_d = 1'b0;
            end
            PASS: begin
               led_d  = 1'b1;
               busy_d = 1'b1;
            end
            FAIL: begin
               busy_d = 1'b1;
               if (tick_i) begin
                  if (use_code) begin
`ifdef LED_STATUS_ERRCODE_EN
                     // Even slots below 2*code are lit; everything else is dark.
                     led_d = (pos_q < pulse_end) && !pos_q[0];
                     pos_d = (pos_q == seq_last) ? '0 : pos_q + 1'b1;
`endif
                  end else if (phase_q == PH_LAST) begin
                     phase_d = '0;
                     led_d   = !led_q;
                  end else begin
                     phase_d = phase_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               led_d   = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         phase_q <= phase_d;
      end
   end

`ifdef LED_STATUS_ERRCODE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q <= '0;
         pos_q  <= '0;
      end else begin
         code_q <= code_d;
         pos_q  <= pos_d;
      end
   end
`endif

   assign led_o  = led_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/led_status_multi.sv
// Purpose : N_CH independent test-result LED indicators sharing one free-running tick prescaler.
// Latency : done -> led/busy one clk edge; blink/code timing quantised to the shared tick.
// Backpressure: none; every done pulse is accepted immediately.
// Ports   : clk, rst_n (async, active-low); done/pass per-channel result strobe and flag;
//           err_code channel k at [k*CODE_W +: CODE_W]; clr global clear; led, busy registered.
// Config  : LED_STATUS_ERRCODE_EN enables the error-code pulse display in FAIL.
module led_status_multi
   import led_status_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int TICK        = 6_250_000,
   parameter int BLINK_TICKS = 4,
   parameter int CODE_W      = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          done,
   input  logic [N_CH-1:0]          pass,
   input  logic [N_CH*CODE_W-1:0]   err_code,
   input  logic                     clr,
   output logic [N_CH-1:0]          led,
   output logic [N_CH-1:0]          busy
);

   localparam int              CNT_W    = clog2(TICK);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   // Prescaler is never cleared by clr or done, so channel phase is only tick-accurate.
   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      led_status_ch #(
         .BLINK_TICKS(BLINK_TICKS),
         .CODE_W     (CODE_W)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .tick_i (tick),
         .done_i (done[k]),
         .pass_i (pass[k]),
         .code_i (err_code[k*CODE_W +: CODE_W]),
         .clr_i  (clr),
         .led_o  (led[k]),
         .busy_o (busy[k])
      );
   end

endmodule

// File: tb/tb_led_status_multi.sv
// Purpose : directed self-checking bench for led_status_multi (N_CH=2, TICK=4, BLINK_TICKS=2).
// Latency : expectations are queued per cycle and compared one edge later.
// Backpressure: n/a.
module tb_led_status_multi;

   localparam int N_CH   = 2;
   localparam int TICK   = 4;
   localparam int BLINK  = 2;
   localparam int CODE_W = 3;

   logic                   clk;
   logic                   rst_n;
   logic [N_CH-1:0]        done;
   logic [N_CH-1:0]        pass;
   logic [N_CH*CODE_W-1:0] err_code;
   logic                   clr;
   logic [N_CH-1:0]        led;
   logic [N_CH-1:0]        busy;

   led_status_multi #(
      .N_CH       (N_CH),
      .TICK       (TICK),
      .BLINK_TICKS(BLINK),
      .CODE_W     (CODE_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .done     (done),
      .pass     (pass),
      .err_code (err_code),
      .clr      (clr),
      .led      (led),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [1:0] led;
      logic [1:0] busy;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   e      = 0;   // rising edges since reset release

   // Ticks are consumed at edges e where e % TICK == 0; count those in (entry, at].
   function automatic logic blink_exp(input int entry, input int at);
      int n;
      n = at / TICK - entry / TICK;
      return ((n / BLINK) % 2) == 1;
   endfunction

`ifdef LED_STATUS_ERRCODE_EN
   function automatic logic code_exp(input int entry, input int at, input int code);
      int n;
      int slot;
      n = at / TICK - entry / TICK;
      if (n == 0) return 1'b0;
      slot = (n - 1) % (2 * code + 8);
      return (slot < 2 * code) && (slot % 2 == 0);
   endfunction
`endif

   task automatic compare_pop();
      exp_t x;
      x = sb.pop_front();
      checks++;
      assert (led === x.led && busy === x.busy)
      else begin
         errors++;
         $error("FAIL %s e=%0d: led=%b busy=%b, expected led=%b busy=%b",
                x.tag, e, led, busy, x.led, x.busy);
      end
   endtask

   // Queue the expectation for the coming edge, advance one edge, compare.
   task automatic cyc(input string tag, input logic [1:0] el, input logic [1:0] eb);
      sb.push_back('{tag, el, eb});
      @(posedge clk);
      e++;
      #1;
      compare_pop();
   endtask

   task automatic chk_now(input string tag, input logic [1:0] el, input logic [1:0] eb);
      sb.push_back('{tag, el, eb});
      compare_pop();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int E1, E2, E3, first_tog;
      logic l0, l1;

      rst_n = 1'b0; done = '0; pass = '0; err_code = '0; clr = 1'b0;
      #3;
      chk_now("reset_state", 2'b00, 2'b00);
      repeat (3) cyc("reset_hold", 2'b00, 2'b00);
      rst_n = 1'b1;
      e = 0;

      // Idle after reset
      repeat (100) cyc("idle", 2'b00, 2'b00);

      // Channel 0 pass, solid
      done = 2'b01; pass = 2'b01;
      cyc("pass_entry", 2'b01, 2'b01);
      done = '0; pass = '0;
      repeat (200) cyc("pass_hold", 2'b01, 2'b01);

      // Channel 1 fail, plain blink
      E1 = e + 1;
      done = 2'b10; pass = 2'b00; err_code = '0;
      cyc("fail_entry", 2'b01, 2'b11);
      done = '0;
      first_tog = -1;
      for (int i = 0; i < 64; i++) begin
         l1 = blink_exp(E1, e + 1);
         cyc("fail_blink", {l1, 1'b1}, 2'b11);
         if (first_tog < 0 && led[1] === 1'b1) first_tog = e - E1;
      end
      checks++;
      assert (first_tog >= 5 && first_tog <= 8)
      else begin
         errors++;
         $error("FAIL first_toggle: %0d cycles after entry, expected 5..8", first_tog);
      end

      // Both channels re-latched as FAIL in one cycle; ch0 code 3, ch1 code 0
      E2 = e + 1;
      done = 2'b11; pass = 2'b00; err_code = {3'd0, 3'd3};
      cyc("relatch_entry", 2'b00, 2'b11);
      done = '0; err_code = '0;
      for (int i = 0; i < 120; i++) begin
`ifdef LED_STATUS_ERRCODE_EN
         l0 = code_exp(E2, e + 1, 3);
`else
         l0 = blink_exp(E2, e + 1);
`endif
         l1 = blink_exp(E2, e + 1);
         cyc("code_or_blink", {l1, l0}, 2'b11);
      end

      // clr and done[0] together: done wins for ch0, ch1 cleared
      clr = 1'b1; done = 2'b01; pass = 2'b01;
      cyc("clr_done", 2'b01, 2'b01);
      clr = 1'b0; done = '0; pass = '0;
      repeat (10) cyc("after_clr", 2'b01, 2'b01);

      // Reset mid-blink
      E3 = e + 1;
      done = 2'b10; pass = 2'b00;
      cyc("fail2_entry", 2'b01, 2'b11);
      done = '0;
      for (int i = 0; i < 12; i++) begin
         l1 = blink_exp(E3, e + 1);
         cyc("fail2_blink", {l1, 1'b1}, 2'b11);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk_now("rst_async", 2'b00, 2'b00);
      repeat (2) cyc("rst_held", 2'b00, 2'b00);
      rst_n = 1'b1;
      e = 0;
      repeat (40) cyc("post_rst_idle", 2'b00, 2'b00);
      done = 2'b10; pass = 2'b10;
      cyc("post_rst_pass", 2'b10, 2'b10);
      done = '0; pass = '0;
      repeat (5) cyc("post_rst_hold", 2'b10, 2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
